// File: rtl/stream_tx_scheduler_ece496.sv
// stream_tx_scheduler_ece496: shares one UART TX between up to eight
// datastreams (round-robin, per-grant byte quota, 1-byte A0|id header)
// and an exclusive, unframed AT-command path.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   sending_flag          master enable
//   want_at               AT mode request
//   at_valid/at_data      AT byte source, popped by at_pop
//   selected_streams      per-stream enable mask
//   stream_valid/data     per-stream FIFO status and head byte
//   stream_pop            one-hot pop of the granted stream
//   burst_len             max data bytes per grant (0 means 1)
//   tx_ready              UART able to accept a byte
//   tx_start/tx_data      one-cycle byte launch to the UART
//   grant_id              {0,id} stream grant, 1000 AT, 1111 none
module stream_tx_scheduler_ece496 #(
  parameter int NUM_STREAMS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sending_flag,
  input  logic                     want_at,
  input  logic                     at_valid,
  input  logic [7:0]               at_data,
  output logic                     at_pop,
  input  logic [NUM_STREAMS-1:0]   selected_streams,
  input  logic [NUM_STREAMS-1:0]   stream_valid,
  input  logic [8*NUM_STREAMS-1:0] stream_data,
  output logic [NUM_STREAMS-1:0]   stream_pop,
  input  logic [7:0]               burst_len,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [3:0]               grant_id
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] AT_SEND = 3'd1;
  localparam logic [2:0] AT_GAP  = 3'd2;
  localparam logic [2:0] PICK    = 3'd3;
  localparam logic [2:0] HDR     = 3'd4;
  localparam logic [2:0] DATA    = 3'd5;
  localparam logic [2:0] GAP     = 3'd6;

  logic [2:0] state;
  logic [2:0] state_n;
  logic [2:0] rr_ptr;
  logic [2:0] cur_id;
  logic [7:0] cnt;
  logic [7:0] quota;

  logic [NUM_STREAMS-1:0] eligible;
  logic       hit;
  logic [2:0] hit_id;
  logic [2:0] cand;
  logic       cur_valid;
  logic       cur_sel;
  logic [7:0] cur_byte;
  logic       at_fire;
  logic       hdr_fire;
  logic       dat_fire;
  logic       grant_more;

  assign eligible  = selected_streams & stream_valid;
  assign cur_valid = stream_valid[cur_id];
  assign cur_sel   = selected_streams[cur_id];
  assign cur_byte  = stream_data[{cur_id, 3'b000} +: 8];

  // First eligible id at or after rr_ptr, wrapping mod 8.
  always_comb begin
    hit    = 1'b0;
    hit_id = rr_ptr;
    cand   = rr_ptr;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      cand = rr_ptr + 3'(k);
      if (!hit && eligible[cand]) begin
        hit    = 1'b1;
        hit_id = cand;
      end
    end
  end

  assign at_fire  = (state == AT_SEND) && sending_flag
                 && want_at && tx_ready && at_valid;
  assign hdr_fire = (state == HDR) && sending_flag && tx_ready;
  assign dat_fire = (state == DATA) && sending_flag
                 && tx_ready && cur_valid;

  // cnt==0 marks the gap right after the header: one data
  // attempt always follows a header.
  assign grant_more = (cnt == 8'd0)
                   || ((cnt < quota) && cur_valid && cur_sel);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (sending_flag)
          state_n = want_at ? AT_SEND : PICK;
      end
      AT_SEND: begin
        if (!sending_flag || !want_at) state_n = IDLE;
        else if (at_fire)              state_n = AT_GAP;
      end
      AT_GAP: begin
        state_n = (sending_flag && want_at) ? AT_SEND : IDLE;
      end
      PICK: begin
        if (!sending_flag || want_at) state_n = IDLE;
        else if (hit)                 state_n = HDR;
      end
      HDR: begin
        if (!sending_flag)  state_n = IDLE;
        else if (hdr_fire)  state_n = GAP;
      end
      DATA: begin
        if (!sending_flag)  state_n = IDLE;
        else if (dat_fire)  state_n = GAP;
        else if (!cur_valid) state_n = PICK;
      end
      GAP: begin
        if (!sending_flag)   state_n = IDLE;
        else if (grant_more) state_n = DATA;
        else                 state_n = PICK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 3'd0;
      cur_id <= 3'd0;
      cnt    <= 8'd0;
      quota  <= 8'd1;
    end else begin
      state <= state_n;
      if ((state == PICK) && sending_flag && !want_at && hit) begin
        cur_id <= hit_id;
        rr_ptr <= hit_id + 3'd1;
      end
      if (hdr_fire) begin
        quota <= (burst_len == 8'd0) ? 8'd1 : burst_len;
        cnt   <= 8'd0;
      end
      if (dat_fire)
        cnt <= cnt + 8'd1;
    end
  end

  assign tx_start   = at_fire | hdr_fire | dat_fire;
  assign at_pop     = at_fire;
  assign stream_pop = dat_fire ? (NUM_STREAMS'(1) << cur_id)
                               : '0;

  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      at_fire:  tx_data = at_data;
      hdr_fire: tx_data = 8'hA0 | {5'b00000, cur_id};
      dat_fire: tx_data = cur_byte;
      default:  tx_data = 8'h00;
    endcase
  end

  always_comb begin
    grant_id = 4'b1111;
    case (state)
      HDR, DATA, GAP:  grant_id = {1'b0, cur_id};
      AT_SEND, AT_GAP: grant_id = 4'b1000;
      default:         grant_id = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_stream_tx_scheduler_ece496.sv
// tb_stream_tx_scheduler_ece496: directed + randomized bench with a
// transaction-level reference model of the byte stream.
module tb_stream_tx_scheduler_ece496;

  logic        clock = 1'b0;
  logic        reset;
  logic        sending_flag;
  logic        want_at;
  logic        at_valid;
  logic [7:0]  at_data;
  logic        at_pop;
  logic [7:0]  selected_streams;
  logic [7:0]  stream_valid;
  logic [63:0] stream_data;
  logic [7:0]  stream_pop;
  logic [7:0]  burst_len;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  grant_id;

  always #5 clock = ~clock;

  stream_tx_scheduler_ece496 dut (
    .clock            (clock),
    .reset            (reset),
    .sending_flag     (sending_flag),
    .want_at          (want_at),
    .at_valid         (at_valid),
    .at_data          (at_data),
    .at_pop           (at_pop),
    .selected_streams (selected_streams),
    .stream_valid     (stream_valid),
    .stream_data      (stream_data),
    .stream_pop       (stream_pop),
    .burst_len        (burst_len),
    .tx_ready         (tx_ready),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .grant_id         (grant_id)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] pop;
    logic       ap;
    logic [3:0] gid;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [8][512];
  int         head [8];
  int         tail [8];
  logic [7:0] at_mem [64];
  int         at_head;
  int         at_tail;
  int         exp_ptr;
  int         checks;
  int         failures;
  int         cyc;
  int         nlaunch;
  int         last_start;
  int         first_cyc;
  int         rdy_mode;
  logic [7:0] pend_pop;
  logic       pend_at;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      stream_valid[i] = head[i] < tail[i];
      stream_data[8*i +: 8] = mem[i][9'(head[i])];
    end
    at_valid = at_head < at_tail;
    at_data  = at_mem[6'(at_head)];
  endtask

  task automatic load_stream(int id, int n);
    for (int j = 0; j < n; j++) begin
      mem[id][9'(tail[id])] = 8'($urandom);
      tail[id]++;
    end
    drive();
  endtask

  // Reference: round-robin over current queue contents, header
  // then min(quota, remaining) bytes per grant.
  task automatic build_streams(logic [7:0] sel, logic [7:0] bl);
    int   left [8];
    int   pos [8];
    int   q;
    int   found;
    int   n;
    exp_t e;
    q = (bl == 8'd0) ? 1 : int'(bl);
    for (int i = 0; i < 8; i++) begin
      left[i] = tail[i] - head[i];
      pos[i]  = head[i];
    end
    for (int g = 0; g < 1000; g++) begin
      found = -1;
      for (int k = 0; k < 8; k++) begin
        if (found < 0 && sel[(exp_ptr + k) % 8]
            && left[(exp_ptr + k) % 8] > 0)
          found = (exp_ptr + k) % 8;
      end
      if (found < 0) break;
      e.b   = 8'hA0 + 8'(found);
      e.pop = 8'h00;
      e.ap  = 1'b0;
      e.gid = 4'(found);
      exp_q.push_back(e);
      n = (q < left[found]) ? q : left[found];
      for (int j = 0; j < n; j++) begin
        e.b   = mem[found][9'(pos[found])];
        e.pop = 8'(1 << found);
        exp_q.push_back(e);
        pos[found]++;
        left[found]--;
      end
      exp_ptr = (found + 1) % 8;
    end
  endtask

  task automatic observe();
    exp_t e;
    cyc++;
    pend_pop = stream_pop;
    pend_at  = at_pop;
    if (tx_start) begin
      nlaunch++;
      if (first_cyc < 0) first_cyc = cyc;
      chk("launch_ready", 32'(tx_ready), 32'd1);
      if (last_start >= 0)
        chk("launch_spacing", 32'(cyc - last_start >= 2), 32'd1);
      last_start = cyc;
      chk("launch_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.b));
        chk("stream_pop", 32'(stream_pop), 32'(e.pop));
        chk("at_pop", 32'(at_pop), 32'(e.ap));
        chk("grant_id", 32'(grant_id), 32'(e.gid));
      end
    end else begin
      chk("pop_without_start", 32'({at_pop, stream_pop}), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    observe();
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++)
      if (pend_pop[i]) head[i]++;
    if (pend_at) at_head++;
    pend_pop = 8'h00;
    pend_at  = 1'b0;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    drive();
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (8) tick();
  endtask

  task automatic wait_launch(string tag);
    int n0;
    int k;
    n0 = nlaunch;
    k  = 0;
    while (nlaunch == n0 && k < 30) begin
      tick();
      k++;
    end
    chk(tag, 32'(nlaunch - n0), 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_at_pop"}, 32'(at_pop), 32'd0);
    chk({tag, "_stream_pop"}, 32'(stream_pop), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'hF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ptr = 0;
    tick();
  endtask

  initial begin
    int set_cyc;
    int n0;
    logic [7:0] sel;
    logic [7:0] bl;
    exp_t e;

    checks = 0; failures = 0; cyc = 0; nlaunch = 0;
    last_start = -1; first_cyc = -1; rdy_mode = 0;
    exp_ptr = 0; at_head = 0; at_tail = 0;
    pend_pop = 8'h00; pend_at = 1'b0;
    for (int i = 0; i < 8; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    reset = 1'b1; sending_flag = 1'b0; want_at = 1'b0;
    selected_streams = 8'h00; burst_len = 8'd1;
    tx_ready = 1'b1; stream_data = '0; stream_valid = '0;
    at_data = 8'h00; at_valid = 1'b0;
    drive();
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Stream 2 only, burst 3, 5 bytes
    selected_streams = 8'h04;
    burst_len = 8'd3;
    load_stream(2, 5);
    build_streams(selected_streams, burst_len);
    chk("s2_expected_len", 32'(exp_q.size()), 32'd7);
    first_cyc = -1;
    set_cyc = cyc;
    sending_flag = 1'b1;
    drain("s2", 200);
    chk("s2_first_latency", 32'(first_cyc - set_cyc), 32'd3);
    chk("s2_idle_gid", 32'(grant_id), 32'hF);

    // Streams 0,3,7 with burst 1; rr wraps 7->0
    sending_flag = 1'b0;
    do_reset();
    sending_flag = 1'b1;
    selected_streams = 8'h89;
    burst_len = 8'd1;
    load_stream(0, 2);
    load_stream(3, 1);
    load_stream(7, 1);
    build_streams(selected_streams, burst_len);
    drain("rr", 200);
    chk("rr_idle_gid", 32'(grant_id), 32'hF);

    // AT mode: 4 unframed bytes
    sending_flag = 1'b0;
    repeat (2) tick();
    for (int j = 0; j < 4; j++) begin
      at_mem[6'(at_tail)] = 8'($urandom);
      e.b = at_mem[6'(at_tail)];
      e.pop = 8'h00;
      e.ap = 1'b1;
      e.gid = 4'b1000;
      exp_q.push_back(e);
      at_tail++;
    end
    drive();
    want_at = 1'b1;
    sending_flag = 1'b1;
    drain("at", 100);
    chk("at_hold_gid", 32'(grant_id), 32'h8);
    want_at = 1'b0;
    repeat (2) tick();
    chk("at_exit_gid", 32'(grant_id), 32'hF);

    // burst_len 0 behaves as 1
    selected_streams = 8'h20;
    burst_len = 8'd0;
    load_stream(5, 3);
    build_streams(selected_streams, burst_len);
    chk("b0_expected_len", 32'(exp_q.size()), 32'd6);
    drain("b0", 200);

    // tx_ready low for 10 cycles in DATA
    selected_streams = 8'h10;
    burst_len = 8'd2;
    rdy_mode = 0;
    load_stream(4, 2);
    build_streams(selected_streams, burst_len);
    wait_launch("hold_hdr_seen");
    rdy_mode = 2;
    tx_ready = 1'b0;
    n0 = nlaunch;
    repeat (10) tick();
    chk("hold_no_start", 32'(nlaunch - n0), 32'd0);
    chk("hold_gid", 32'(grant_id), 32'h4);
    rdy_mode = 0;
    tx_ready = 1'b1;
    drain("hold", 100);

    // Randomized rounds with a random tx_ready
    for (int r = 0; r < 6; r++) begin
      rdy_mode = 1;
      sel = 8'($urandom);
      bl = 8'($urandom_range(0, 3));
      selected_streams = sel;
      burst_len = bl;
      for (int i = 0; i < 8; i++)
        if (sel[i]) load_stream(i, $urandom_range(0, 5));
      build_streams(sel, bl);
      drain("rand", 600);
    end

    // Reset during GAP, then rr restarts at 0
    rdy_mode = 0;
    tx_ready = 1'b1;
    selected_streams = 8'h08;
    burst_len = 8'd2;
    load_stream(3, 2);
    build_streams(selected_streams, burst_len);
    wait_launch("rst_hdr_seen");
    chk("rst_gap_gid", 32'(grant_id), 32'h3);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_gap");
    exp_q.delete();
    exp_ptr = 0;
    repeat (2) tick();
    selected_streams = 8'h09;
    load_stream(0, 2);
    reset = 1'b0;
    build_streams(selected_streams, burst_len);
    e = exp_q[0];
    chk("rst_first_hdr_model", 32'(e.b), 32'hA0);
    drain("rst", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_tx_scheduler_ece496.md
# stream_tx_scheduler_ece496

Byte-level transmit scheduler between the per-stream data FIFOs and the UART transmitter. It sits after the stream-selection stage. It shares the single UART TX between up to eight selected datastreams using round-robin with a per-grant byte quota. It prefixes every grant with a one-byte stream header. It also gives exclusive, unframed UART access to the AT-command path when AT mode is requested.

## Interface
- NUM_STREAMS, 8, number of datastream requesters; ids 0..7, 3-bit id.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset to IDLE and all reset values below.
- sending_flag  in  1  master enable; low = stop after the in-flight byte and return to IDLE.
- want_at  in  1  AT mode request; sampled in IDLE and PICK only.
- at_valid  in  1  AT byte available.
- at_data  in  8  AT byte.
- at_pop  out  1  one-cycle pop of the AT source; coincident with tx_start.
- selected_streams  in  8  stream enable mask; bit i enables stream i.
- stream_valid  in  8  bit i = stream i FIFO non-empty.
- stream_data  in  64  stream i byte on bits [8i+7:8i].
- stream_pop  out  8  one-hot pop of the granted stream; coincident with its data tx_start.
- burst_len  in  8  maximum data bytes per grant; sampled in HDR; 0 treated as 1.
- tx_ready  in  1  UART idle and able to accept a byte.
- tx_start  out  1  one-cycle byte launch.
- tx_data  out  8  byte to send; valid in the tx_start cycle.
- grant_id  out  4  {0, id} during a stream grant; 4'b1000 in AT mode; 4'b1111 otherwise.

## Operation
- States: IDLE, AT_SEND, AT_GAP, PICK, HDR, DATA, GAP.
- IDLE
  - sending_flag & want_at -> AT_SEND.
  - sending_flag & ~want_at -> PICK.
  - Otherwise stay.
- AT_SEND
  - If tx_ready & at_valid: tx_start=1, tx_data=at_data, at_pop=1, go to AT_GAP.
  - If ~sending_flag | ~want_at with nothing launched: go to IDLE.
- AT_GAP
  - Lasts one cycle and ignores tx_ready.
  - Then -> AT_SEND if sending_flag & want_at, else IDLE.
- PICK
  - ~sending_flag -> IDLE.
  - want_at -> IDLE, which re-enters AT next cycle.
  - Otherwise search ids rr_ptr, rr_ptr+1, ... (mod 8) for the first i with selected_streams[i] & stream_valid[i].
  - Found: latch cur_id=i, set rr_ptr=i+1 (3-bit wrap, 7->0), go to HDR.
  - None found: stay in PICK.
- HDR
  - On the first tx_ready cycle: tx_start=1, tx_data=8'hA0|cur_id.
  - Latch quota = (burst_len==0 ? 1 : burst_len) and cnt=0.
  - Go to GAP.
- GAP
  - Lasts one cycle and ignores tx_ready.
  - Then -> DATA if grant continues, else PICK; if ~sending_flag, IDLE.
- DATA
  - If tx_ready & stream_valid[cur_id]: tx_start=1, tx_data=stream byte, stream_pop[cur_id]=1, cnt++, go to GAP.
  - If ~stream_valid[cur_id]: grant ends, go to PICK with no byte sent.
- A grant continues while cnt<quota, stream_valid[cur_id], selected_streams[cur_id] and sending_flag all hold.
- The header is always followed by at least one data attempt. An empty stream at DATA ends the grant with the header only.
- selected_streams changes take effect at the next PICK or grant-continue check. A cleared bit ends the current grant after the in-flight byte.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, cur_id=0, cnt=0, quota=1.
  - tx_start=0, tx_data=8'h00, at_pop=0, stream_pop=0, grant_id=4'b1111.
- All outputs are registered-state decodes. tx_start, at_pop and stream_pop are combinational in the issuing state and are high for exactly one cycle per byte.
- The UART must drop tx_ready within one cycle of tx_start. The GAP states guarantee no second launch in the cycle after tx_start.
- Latency:
  - IDLE->PICK: 1 cycle.
  - PICK (hit) -> HDR: 1 cycle.
  - HDR tx_start occurs in the first HDR cycle with tx_ready.
  - Minimum spacing between launches: 2 cycles.
- cnt and quota are 8-bit; quota=255 allows 255 data bytes; cnt never wraps.
- Reset asserted mid-byte: outputs return to reset values immediately (async). The UART owns completion of any launched byte.
- sending_flag drop mid-grant: the byte already launched completes. No further tx_start; go to IDLE. rr_ptr is retained.

## Test plan
- Stream 2 only, burst_len=3, 5 bytes queued, tx_ready tied high:
  - Bytes A2,d0,d1,d2, then A2,d3,d4, then PICK idles.
  - grant_id=0010 throughout.
- Streams 0,3,7 valid, burst_len=1:
  - Header order A0,A3,A7,A0 (rr wrap 7->0).
  - One data byte each.
- want_at=1, sending_flag=1, 4 AT bytes:
  - 4 tx_start with at_pop, no headers, grant_id=1000.
  - Drop want_at -> IDLE, grant_id=1111.
- burst_len=0 with stream 5 valid:
  - A5 then exactly one data byte per grant.
- Hold tx_ready low 10 cycles in DATA:
  - No tx_start, no pop.
  - Raise tx_ready -> one launch, next launch no earlier than 2 cycles later.
- Assert reset during GAP:
  - All outputs at reset values the same cycle.
  - After release with sending_flag=1, next header is A0 (rr_ptr=0).
